fb_write_queue: RTL and testbench

FB_WRITE_QUEUE -- requirements
Module: fb_write_queue

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_sync_fifo.sv | 57 +++++
 rtl/fb_write_queue.sv | 92 +++++++++
 tb/tb_fb_write_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the queued write entry type.
// Consumed by fb_sync_fifo and fb_write_queue.
package fb_pkg;

  localparam logic [31:0] FB_BASE_ADDR = 32'hD000_0000;
  localparam int unsigned FB_WIDTH     = 320;
  localparam int unsigned FB_HEIGHT    = 240;
  localparam int unsigned FB_WORDS     = FB_WIDTH * FB_HEIGHT;

  // One pending framebuffer write: 17-bit word address plus RGB888 pixel.
  typedef struct packed {
    logic [16:0] addr;
    logic [23:0] rgb;
  } fb_entry_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock FIFO of fb_entry_t with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module fb_sync_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fb_entry_t              push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fb_entry_t              head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fb_entry_t        mem [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_write_queue.sv
// Bus-to-framebuffer write queue: decodes bus writes into framebuffer word
// writes, buffers them in fb_sync_fifo and drains them to the framebuffer.
// Optional macro FB_BOUNDS_CHECK_EN enables alignment/range checking with
// bus_error; without it every write is accepted and the offset is truncated.
//
// Framebuffer handshake: fb_wen is valid, fb_ready is ready. An entry is
// presented while fb_wen=1, fb_waddr/fb_wdata stay stable until a cycle with
// fb_wen && fb_ready, in which the entry is consumed at the rising edge.
// Bus side: a write is taken at the edge of a cycle with bus_wen=1 and
// bus_request_stall=0 and bus_error=0; a stalled master holds its request.
module fb_write_queue
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] FB_BASE_ADDR = fb_pkg::FB_BASE_ADDR,
  parameter int unsigned FB_WORDS     = fb_pkg::FB_WORDS
) (
  input  logic                          ahb_clk,
  input  logic                          rst,
  input  logic                          bus_wen,
  input  logic                          bus_ren,
  input  logic [ADDR_WIDTH-1:0]         bus_addr,
  input  logic [DATA_WIDTH-1:0]         bus_wdata,
  output logic                          bus_request_stall,
  output logic                          bus_error,
  output logic [DATA_WIDTH-1:0]         bus_rdata,
  output logic                          fb_wen,
  output logic [16:0]                   fb_waddr,
  output logic [23:0]                   fb_wdata,
  input  logic                          fb_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import fb_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(FB_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] WORDS_C = ADDR_WIDTH'(FB_WORDS);

  logic [ADDR_WIDTH-1:0] off;
  logic                  legal;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  fb_entry_t             push_data;
  fb_entry_t             head;
  logic                  unused_bits;

  // Word offset from the framebuffer base, wrapping at the bus width.
  assign off = (bus_addr - BASE_C) >> 2;

`ifdef FB_BOUNDS_CHECK_EN
  assign legal       = (bus_addr[1:0] == 2'b00) && (bus_addr >= BASE_C) && (off < WORDS_C);
  assign bus_error   = !rst && bus_wen && !legal;
  assign unused_bits = ^{bus_ren, bus_wdata[DATA_WIDTH-1:24], off[ADDR_WIDTH-1:17]};
`else
  assign legal       = 1'b1;
  assign bus_error   = 1'b0;
  assign unused_bits = ^{bus_ren, bus_wdata[DATA_WIDTH-1:24], off[ADDR_WIDTH-1:17], WORDS_C};
`endif

  // Stall uses the current full flag even when a pop frees a slot this cycle.
  assign bus_request_stall = !rst && bus_wen && legal && fifo_full;
  assign push              = !rst && bus_wen && legal && !fifo_full;
  assign bus_rdata         = '0;

  assign push_data.addr = off[16:0];
  assign push_data.rgb  = bus_wdata[23:0];

  // Head entry comes straight from FIFO storage; zeroed when nothing is queued
  // or reset is active so no stale entry is ever presented.
  assign fb_wen   = !fifo_empty && !rst;
  assign fb_waddr = fb_wen ? head.addr : '0;
  assign fb_wdata = fb_wen ? head.rgb  : '0;
  assign pop      = fb_wen && fb_ready;

  fb_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ahb_clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

endmodule

// File: tb/tb_fb_write_queue.sv
// Self-checking bench for fb_write_queue: table of single-cycle bus
// transactions, hand-written sequences for fill/stall, push+pop and reset,
// and a scoreboard queue checked against every framebuffer write.
module tb_fb_write_queue;

  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = 41;

  logic          ahb_clk;
  logic          rst;
  logic          bus_wen;
  logic          bus_ren;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          fb_ready;
  logic          bus_request_stall;
  logic          bus_error;
  logic [31:0]   bus_rdata;
  logic          fb_wen;
  logic [16:0]   fb_waddr;
  logic [23:0]   fb_wdata;
  logic [CW-1:0] fifo_count;

  int n_pass;
  int n_total;
  logic mon_en;
  logic [ENTRY_W-1:0] exp_q[$];
  logic [ENTRY_W-1:0] mon_e;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic        exp_push;
    logic [16:0] exp_addr;
  } vec_t;

  vec_t vecs[10];

  fb_write_queue #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .ahb_clk           (ahb_clk),
    .rst               (rst),
    .bus_wen           (bus_wen),
    .bus_ren           (bus_ren),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_request_stall (bus_request_stall),
    .bus_error         (bus_error),
    .bus_rdata         (bus_rdata),
    .fb_wen            (fb_wen),
    .fb_waddr          (fb_waddr),
    .fb_wdata          (fb_wdata),
    .fb_ready          (fb_ready),
    .fifo_count        (fifo_count)
  );

  // Clock and watchdog
  initial begin
    ahb_clk = 1'b0;
    forever #5 ahb_clk = ~ahb_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ahb_clk);
    #1;
  endtask

  // Drive one bus cycle, check the combinational bus response, and record
  // the expected framebuffer entry once the accepting edge has passed.
  task automatic bus_cycle(input string name, input logic wen, input logic ren,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_stall, input logic exp_err,
                           input logic exp_push, input logic [16:0] exp_addr);
    bus_wen   = wen;
    bus_ren   = ren;
    bus_addr  = addr;
    bus_wdata = data;
    @(negedge ahb_clk);
    check({name, "_stall"}, bus_request_stall, exp_stall);
    check({name, "_error"}, bus_error, exp_err);
    check({name, "_rdata"}, bus_rdata, 64'd0);
    tick();
    if (exp_push) exp_q.push_back({exp_addr, data[23:0]});
    bus_wen = 1'b0;
    bus_ren = 1'b0;
  endtask

  // Scoreboard monitor: occupancy and fb_wen track the expected queue, and
  // every consumed framebuffer write matches the oldest expected entry.
  always @(negedge ahb_clk) begin
    if (mon_en && !rst) begin
      check("mon_fifo_count", fifo_count, exp_q.size());
      check("mon_fb_wen", fb_wen, exp_q.size() != 0);
      if (fb_wen && fb_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("mon_fb_entry", {fb_waddr, fb_wdata}, mon_e);
      end
    end
  end

  initial begin
    n_pass    = 0;
    n_total   = 0;
    mon_en    = 1'b0;
    rst       = 1'b1;
    bus_wen   = 1'b0;
    bus_ren   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    fb_ready  = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'hD000_0000, 32'h00FF_0000, 1'b0, 1'b1, 17'h00000};
    vecs[1] = '{1'b1, 1'b0, 32'hD000_0004, 32'h1234_5678, 1'b0, 1'b1, 17'h00001};
    vecs[2] = '{1'b1, 1'b0, 32'hD004_AFFC, 32'hAABB_CCDD, 1'b0, 1'b1, 17'h12BFF};
    vecs[3] = '{1'b0, 1'b1, 32'hD000_0008, 32'h0000_0000, 1'b0, 1'b0, 17'h00000};
    vecs[4] = '{1'b1, 1'b1, 32'hD000_0010, 32'h0000_0ABC, 1'b0, 1'b1, 17'h00004};
    vecs[5] = '{1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0, 17'h00000};
`ifdef FB_BOUNDS_CHECK_EN
    vecs[6] = '{1'b1, 1'b0, 32'hD004_B000, 32'h00C0_FFEE, 1'b1, 1'b0, 17'h00000};
    vecs[7] = '{1'b1, 1'b0, 32'hCFFF_FFFC, 32'h0011_2233, 1'b1, 1'b0, 17'h00000};
    vecs[8] = '{1'b1, 1'b0, 32'hD000_0002, 32'h0044_5566, 1'b1, 1'b0, 17'h00000};
    vecs[9] = '{1'b1, 1'b0, 32'hD010_0000, 32'h0077_8899, 1'b1, 1'b0, 17'h00000};
`else
    vecs[6] = '{1'b1, 1'b0, 32'hD004_B000, 32'h00C0_FFEE, 1'b0, 1'b1, 17'h12C00};
    vecs[7] = '{1'b1, 1'b0, 32'hCFFF_FFFC, 32'h0011_2233, 1'b0, 1'b1, 17'h1FFFF};
    vecs[8] = '{1'b1, 1'b0, 32'hD000_0002, 32'h0044_5566, 1'b0, 1'b1, 17'h00000};
    vecs[9] = '{1'b1, 1'b0, 32'hD010_0000, 32'h0077_8899, 1'b0, 1'b1, 17'h00000};
`endif

    // Reset and idle state
    repeat (2) @(posedge ahb_clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge ahb_clk);
    check("rst_fb_wen", fb_wen, 64'd0);
    check("rst_fb_waddr", fb_waddr, 64'd0);
    check("rst_fb_wdata", fb_wdata, 64'd0);
    check("rst_fifo_count", fifo_count, 64'd0);
    check("rst_stall", bus_request_stall, 64'd0);
    check("rst_error", bus_error, 64'd0);
    tick();

    // Single write: presented the cycle after acceptance, gone after that
    fb_ready = 1'b1;
    bus_cycle("first_write", 1'b1, 1'b0, 32'hD000_0000, 32'h00FF_0000, 1'b0, 1'b0, 1'b1, 17'h0);
    @(negedge ahb_clk);
    check("first_fb_wen", fb_wen, 64'd1);
    check("first_fb_waddr", fb_waddr, 64'd0);
    check("first_fb_wdata", fb_wdata, 64'hFF0000);
    tick();
    @(negedge ahb_clk);
    check("first_fb_wen_clear", fb_wen, 64'd0);
    tick();

    // Table of single-cycle bus transactions with the framebuffer draining
    for (int i = 0; i < 10; i++) begin
      bus_cycle($sformatf("vec%0d", i), vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].data,
                1'b0, vecs[i].exp_err, vecs[i].exp_push, vecs[i].exp_addr);
    end
    repeat (3) tick();

    // Fill to capacity, stall the fifth write, release via fb_ready
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 32'hD000_0000 + 32'(4 * i),
                {8'h00, 8'(i + 1), 16'hBEEF}, 1'b0, 1'b0, 1'b1, 17'(i));
    end
    bus_cycle("read_full", 1'b0, 1'b1, 32'hD000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 17'h0);
    bus_wen   = 1'b1;
    bus_addr  = 32'hD000_0010;
    bus_wdata = 32'h0005_BEEF;
    @(negedge ahb_clk);
    check("fifth_stall", bus_request_stall, 64'd1);
    check("full_count", fifo_count, 64'd4);
    tick();
    @(negedge ahb_clk);
    check("fifth_hold_stall", bus_request_stall, 64'd1);
    tick();
    fb_ready = 1'b1;
    @(negedge ahb_clk);
    check("stall_during_pop", bus_request_stall, 64'd1);
    tick();
    bus_cycle("fifth_accept", 1'b1, 1'b0, 32'hD000_0010, 32'h0005_BEEF, 1'b0, 1'b0, 1'b1, 17'h4);
    repeat (6) tick();
    check("fill_drained", exp_q.size(), 64'd0);

    // Push and pop in the same cycle with two entries queued
    fb_ready = 1'b0;
    bus_cycle("pp0", 1'b1, 1'b0, 32'hD000_0040, 32'h0010_2030, 1'b0, 1'b0, 1'b1, 17'h10);
    bus_cycle("pp1", 1'b1, 1'b0, 32'hD000_0044, 32'h0040_5060, 1'b0, 1'b0, 1'b1, 17'h11);
    fb_ready = 1'b1;
    bus_cycle("pp_both", 1'b1, 1'b0, 32'hD000_0048, 32'h0070_8090, 1'b0, 1'b0, 1'b1, 17'h12);
    @(negedge ahb_clk);
    check("push_pop_count", fifo_count, 64'd2);
    tick();
    repeat (4) tick();

    // Reset with three entries queued: nothing stale drains afterwards
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_cycle($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 32'hD000_0080 + 32'(4 * i),
                32'(i * 32'h0001_0101 + 32'h0000_00AA), 1'b0, 1'b0, 1'b1, 17'(32 + i));
    end
    rst       = 1'b1;
    fb_ready  = 1'b1;
    bus_wen   = 1'b1;
    bus_addr  = 32'hD000_0002;
    bus_wdata = 32'h00DE_AD00;
    @(negedge ahb_clk);
    check("in_rst_stall", bus_request_stall, 64'd0);
    check("in_rst_error", bus_error, 64'd0);
    check("in_rst_rdata", bus_rdata, 64'd0);
    check("in_rst_fb_wen", fb_wen, 64'd0);
    tick();
    rst     = 1'b0;
    bus_wen = 1'b0;
    exp_q.delete();
    @(negedge ahb_clk);
    check("post_rst_fb_wen", fb_wen, 64'd0);
    check("post_rst_count", fifo_count, 64'd0);
    check("post_rst_waddr", fb_waddr, 64'd0);
    check("post_rst_wdata", fb_wdata, 64'd0);
    tick();
    repeat (6) tick();

    check("final_queue_empty", exp_q.size(), 64'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
